// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared opcodes, FSM state type and iteration count for the
//               iterative multiply/divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

    // Operation codes carried on fun_c; bit 1 selects divide, bit 0 signed.
    localparam logic [1:0] FUN_MULTU = 2'b00;
    localparam logic [1:0] FUN_MULT  = 2'b01;
    localparam logic [1:0] FUN_DIVU  = 2'b10;
    localparam logic [1:0] FUN_DIV   = 2'b11;

    // One shift/add or shift/subtract step per operand bit.
    localparam int MD_ITER = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        SIGN = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage : muldiv_pkg
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative 32-step shift-add multiplier / restoring divider
//               with start/busy/done handshake and {hi, lo} result.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_ITER
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       fun_c,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out
);

    localparam int            CW       = $clog2(WIDTH);
    localparam int            SW       = WIDTH + 2;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    state_e               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [1:0]           fun_q, fun_d;
    logic [WIDTH-1:0]     opa_q, opa_d;     // multiplicand / dividend (shifts out MSB-first)
    logic [WIDTH-1:0]     opb_q, opb_d;     // multiplier (shifts right) / divisor
    logic [2*WIDTH-1:0]   acc_q, acc_d;     // product, or {remainder, quotient}
    logic                 negp_q, negp_d;   // negate product / quotient
    logic                 negr_q, negr_d;   // negate remainder
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WIDTH-1:0]     hi_q, hi_d;
    logic [WIDTH-1:0]     lo_q, lo_d;

    logic                 w_is_div;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH:0]       w_add_x;
    logic [WIDTH:0]       w_add_y;
    logic [SW-1:0]        w_sum;
    logic                 w_ge;
    logic                 w_sgn;
    logic                 w_dz;

    assign busy   = busy_q;
    assign done   = done_q;
    assign hi_out = hi_q;
    assign lo_out = lo_q;

    // Capture-time decode of the incoming request.
    assign w_sgn = fun_c[0];
    assign w_dz  = fun_c[1] && (b == '0);

    // Single shared adder: add multiplicand in multiply, subtract divisor in
    // divide (x + ~y + 1). The top sum bit is the "no borrow" flag, i.e. rem >= divisor.
    assign w_is_div = fun_q[1];
    assign w_rem_sh = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
    assign w_add_x  = w_is_div ? w_rem_sh : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
    assign w_add_y  = w_is_div ? ~{1'b0, opb_q} : {1'b0, opa_q};
    assign w_sum    = {1'b0, w_add_x} + {1'b0, w_add_y} + SW'(w_is_div);
    assign w_ge     = w_sum[SW-1];

    // Next-state, datapath and registered-output computation.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fun_d   = fun_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        negp_d  = negp_q;
        negr_d  = negr_q;
        hi_d    = hi_q;
        lo_d    = lo_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    fun_d  = fun_c;
                    // A zero divisor keeps the raw dividend: the unsigned
                    // iteration then naturally yields quotient all-ones and
                    // remainder = dividend, which is exactly the required result.
                    opa_d  = (w_sgn && !w_dz && a[WIDTH-1]) ? -a : a;
                    opb_d  = (w_sgn && b[WIDTH-1]) ? -b : b;
                    negp_d = w_sgn && !w_dz && (a[WIDTH-1] ^ b[WIDTH-1]);
                    negr_d = w_sgn && w_dz == 1'b0 && fun_c[1] && a[WIDTH-1];
                    acc_d  = '0;
                    cnt_d  = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                cnt_d = cnt_q + CW'(1);
                if (w_is_div) begin
                    acc_d = w_ge ? {w_sum[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1}
                                 : {w_rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
                    opa_d = {opa_q[WIDTH-2:0], 1'b0};
                end else begin
                    acc_d = opb_q[0] ? {w_sum[WIDTH:0], acc_q[WIDTH-1:1]}
                                     : {1'b0, acc_q[2*WIDTH-1:1]};
                    opb_d = {1'b0, opb_q[WIDTH-1:1]};
                end
                if (cnt_q == CNT_LAST) begin
                    state_d = SIGN;
                end
            end
            SIGN: begin
                if (!w_is_div) begin
                    {hi_d, lo_d} = negp_q ? -acc_q : acc_q;
                end else begin
                    lo_d = negp_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                    hi_d = negr_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                end
                state_d = DONE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CALC) || (state_d == SIGN);
        done_d = (state_d == DONE);
    end

    // State, datapath and output registers; reset aborts any operation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            fun_q   <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            negp_q  <= 1'b0;
            negr_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            fun_q   <= fun_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            negp_q  <= negp_d;
            negr_q  <= negr_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

endmodule : muldiv_unit
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit against an arithmetic
//               reference model (directed corner cases plus random ops).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  fun_c;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi_out;
    logic [31:0] lo_out;

    int vectors     = 0;
    int miscompares = 0;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .fun_c  (fun_c),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .hi_out (hi_out),
        .lo_out (lo_out)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain 64-bit arithmetic; SV signed division truncates and
    // the remainder follows the dividend's sign.
    function automatic logic [63:0] model(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y);
        longint      sx;
        longint      sy;
        longint      q;
        longint      r;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        case (f)
            FUN_MULTU: p = {32'h0, x} * {32'h0, y};
            FUN_MULT:  p = 64'(sx * sy);
            FUN_DIVU:  p = (y == 32'h0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
            default: begin
                if (y == 32'h0) begin
                    p = {x, 32'hFFFF_FFFF};
                end else begin
                    q = sx / sy;
                    r = sx % sy;
                    p = {r[31:0], q[31:0]};
                end
            end
        endcase
        return p;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic scramble();
        a     = $urandom;
        b     = $urandom;
        fun_c = 2'($urandom_range(0, 3));
    endtask

    // Present a request and return #1 after the accepting edge E0.
    task automatic start_op(input logic [1:0] f, input logic [31:0] x, input logic [31:0] y);
        @(negedge clk);
        start = 1'b1;
        fun_c = f;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
    endtask

    // Called #1 after E0: expects done exactly at E33, busy for 33 samples,
    // one-cycle done pulse, then idle with results held.
    task automatic finish_op(input string tag, input logic [63:0] exp);
        int n  = 0;
        int nb = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) nb++;
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, " latency"}, 64'(n), 64'd33);
        chk({tag, " busy cycles"}, 64'(nb), 64'd33);
        chk({tag, " busy at done"}, {63'h0, busy}, 64'h0);
        chk({tag, " result"}, {hi_out, lo_out}, exp);
        @(posedge clk);
        #1;
        chk({tag, " done pulse/idle"}, {62'h0, done, busy}, 64'h0);
        chk({tag, " result held"}, {hi_out, lo_out}, exp);
    endtask

    task automatic run_op(input string tag, input logic [1:0] f, input logic [31:0] x,
                          input logic [31:0] y, input logic [63:0] exp);
        start_op(f, x, y);
        start = 1'b0;
        scramble();
        finish_op(tag, exp);
    endtask

    initial begin
        logic [1:0]  f;
        logic [31:0] x;
        logic [31:0] y;
        int          seen;

        rst   = 1'b1;
        start = 1'b0;
        fun_c = 2'b00;
        a     = 32'h0;
        b     = 32'h0;
        #12;
        chk("reset outputs", {busy, done, hi_out, lo_out}, 66'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle after reset", {62'h0, busy, done}, 64'h0);

        // Directed cases.
        run_op("multu max", FUN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        run_op("mult -3*7", FUN_MULT, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op("div -7/2", FUN_DIV, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu 100/7", FUN_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});

        // Reset at cycle 10 of CALC aborts without a done pulse.
        start_op(FUN_DIV, 32'h7654_3210, 32'd13);
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async reset outputs", {busy, done, hi_out, lo_out}, 66'h0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        chk("no done after abort", 64'(seen), 64'd0);
        run_op("post-reset divu", FUN_DIVU, 32'd1000, 32'd33, {32'd10, 32'd30});

        run_op("div by zero", FUN_DIV, 32'h1234_5678, 32'h0, 64'h1234_5678_FFFF_FFFF);
        run_op("divu by zero", FUN_DIVU, 32'h8000_0001, 32'h0, 64'h8000_0001_FFFF_FFFF);
        run_op("div overflow", FUN_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
        run_op("div neg/neg", FUN_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, model(FUN_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE));

        // Start held high: accepted at E0 and again at E35 only.
        start_op(FUN_MULT, 32'h8000_0000, 32'h8000_0000);
        f = FUN_DIV;
        x = 32'hDEAD_BEEF;
        y = 32'h0000_1234;
        fun_c = f;
        a     = x;
        b     = y;
        finish_op("held first", 64'h4000_0000_0000_0000);
        @(posedge clk);
        #1;
        chk("held reaccept E35", {63'h0, busy}, 64'h1);
        start = 1'b0;
        scramble();
        finish_op("held second", model(f, x, y));

        // Random operations against the model.
        for (int i = 0; i < 24; i++) begin
            f = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 3))
                0:       x = $urandom_range(0, 255);
                1:       x = 32'h8000_0000 | $urandom;
                default: x = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       y = 32'h0;
                1:       y = $urandom_range(1, 15);
                2:       y = 32'hFFFF_FFFF;
                default: y = $urandom;
            endcase
            run_op($sformatf("rand%0d f%0d %h %h", i, f, x, y), f, x, y, model(f, x, y));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Global guard so the run can never hang.
    initial begin
        #200000;
        $display("FAIL timeout: observed no completion, required finish");
        $fatal(1, "timeout");
    end

endmodule : tb_muldiv_unit
`default_nettype wire
